toggle_bank: RTL
================

TOGGLE_BANK -- requirements
Module: toggle_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent switch/toggle channels, range 1..32.
REQ-002 Parameter DB_CYCLES, default 4: debounce qualification length in clock cycles, range 2..65535.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sw  input  WIDTH  raw switch levels, asynchronous to clk, one bit per channel.
REQ-006 clr  input  WIDTH  synchronous per-channel clear of q.
REQ-007 q  output  WIDTH  registered toggle state per channel.
REQ-008 tog_pulse  output  WIDTH  registered one-cycle strobe, high in the cycle after q[i] toggles.
REQ-009 any_on  output  1  combinational OR of all q bits.

Function
REQ-010 Each channel SHALL pass sw[i] through a 2-flop synchronizer; the second stage is sync[i].
REQ-011 Each channel SHALL hold a debounced level stab[i] and a counter cnt[i] of ceil(log2(DB_CYCLES)) bits.
REQ-012 When sync[i]==stab[i], cnt[i] SHALL be 0 at the next edge.
REQ-013 When sync[i]!=stab[i] and cnt[i]<DB_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-014 When sync[i]!=stab[i] and cnt[i]==DB_CYCLES-1, an update event SHALL occur: stab[i]<=sync[i] and cnt[i]<=0.
REQ-015 An update event with new stab[i]=1 (rising event) SHALL invert q[i] and set tog_pulse[i]=1 at the same edge.
REQ-016 A falling update event SHALL change neither q[i] nor tog_pulse[i].
REQ-017 tog_pulse[i] SHALL be 0 in every cycle not immediately following a rising event.
REQ-018 Latency: sw[i] stable-high from before edge 1 SHALL change q[i] at edge 2+DB_CYCLES.
REQ-019 An sw[i] level held for fewer than DB_CYCLES synchronized cycles SHALL produce no update event.
REQ-020 clr[i]=1 SHALL force q[i]=0 at the next edge, overriding a simultaneous rising event; tog_pulse[i] SHALL then be 0.
REQ-021 clr SHALL NOT affect the synchronizer, stab, or cnt.
REQ-022 Channels SHALL be fully independent; simultaneous events on several channels SHALL each take effect in the same cycle.

Reset
REQ-023 While rst=1, sync, stab, cnt, q and tog_pulse SHALL all be 0 regardless of clk.
REQ-024 Reset asserted mid-qualification SHALL discard the count; after release, qualification SHALL restart from cnt=0.
REQ-025 A switch held high through reset release SHALL produce one rising event, toggling q to 1, 2+DB_CYCLES edges after release.

Configuration
REQ-026 Macro TOGGLE_BANK_DEBOUNCE_EN defined: debounce counters present as in REQ-011..REQ-019.
REQ-027 Macro TOGGLE_BANK_DEBOUNCE_EN undefined: no cnt registers; an update event SHALL occur at every edge where sync[i]!=stab[i]; DB_CYCLES ignored; latency is 3 edges.

Verification
REQ-028 WIDTH=4, DB_CYCLES=4, macro on: sw=4'b0001 from before edge 1 -> q=4'b0001 at edge 6; tog_pulse=4'b0001 for exactly one cycle; any_on=1.
REQ-029 Glitch: sw[1] high for 3 cycles, then low -> q[1] remains 0 and tog_pulse[1] remains 0 throughout.
REQ-030 Press/release/press on sw[2], each level held 10 cycles -> q[2] goes 0->1->0 and tog_pulse[2] pulses twice; no change on the releases.
REQ-031 clr[0]=1 in the same cycle as a rising event on channel 0 -> q[0]=0 and tog_pulse[0]=0; a simultaneous event on channel 3 still toggles q[3].
REQ-032 rst pulsed at cnt=2 mid-qualification with sw[0] held high -> all outputs 0 immediately; q[0]=1 at edge 6 after release.
REQ-033 Macro off: sw=4'b1000 -> q[3]=1 at edge 3; a 1-cycle glitch that survives synchronization -> toggles q.

Source files
------------

// File: rtl/toggle_bank.sv
// toggle_bank: a bank of independent push-on/push-off channels.
// Each raw switch is synchronized and debounced. The debounced level drives
// a toggle register q: every qualified press (a rising update event) inverts
// q[i] and raises a one-cycle tog_pulse[i]. A per-channel clr forces q[i] to 0.
// Build option: define TOGGLE_BANK_DEBOUNCE_EN to include the debounce
// counters. Without it, any change of the synchronized level is taken at the
// next edge and DB_CYCLES has no effect.
module toggle_bank #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw,
    input  logic [WIDTH-1:0] clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] tog_pulse,
    output logic             any_on
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync_q,  sync_d;
    logic [WIDTH-1:0] stab_q,  stab_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic [WIDTH-1:0] pulse_q, pulse_d;
    logic [WIDTH-1:0] upd_s;
    logic [WIDTH-1:0] rise_s;

    // Two-stage synchronizer inputs: stage 1 samples the raw switch.
    always_comb begin
        sync1_d = sw;
        sync_d  = sync1_q;
    end

`ifdef TOGGLE_BANK_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;

    // Debounce: a level differing from stab must persist DB_CYCLES cycles.
    always_comb begin
        cnt_d  = cnt_q;
        stab_d = stab_q;
        upd_s  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_q[i] == stab_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                upd_s[i]  = 1'b1;
                stab_d[i] = sync_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Debounce counter register; cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No debounce: every mismatch between sync and stab is an update event.
    always_comb begin
        upd_s  = sync_q ^ stab_q;
        stab_d = sync_q;
    end
`endif

    // Toggle and strobe: a rising event flips q, clr wins over the flip.
    always_comb begin
        rise_s  = upd_s & stab_d;
        q_d     = q_q;
        pulse_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (clr[i]) begin
                q_d[i]     = 1'b0;
                pulse_d[i] = 1'b0;
            end else if (rise_s[i]) begin
                q_d[i]     = ~q_q[i];
                pulse_d[i] = 1'b1;
            end else begin
                q_d[i]     = q_q[i];
                pulse_d[i] = 1'b0;
            end
        end
    end

    // Channel state registers: synchronizer, debounced level, toggle, strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync_q  <= '0;
            stab_q  <= '0;
            q_q     <= '0;
            pulse_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            q_q     <= q_d;
            pulse_q <= pulse_d;
        end
    end

    assign q         = q_q;
    assign tog_pulse = pulse_q;
    assign any_on    = |q_q;

endmodule
